// File: rtl/bus_ram.sv
// bus_ram: parametrised single-port data RAM on the shared 8-bit processor bus.
// It zero-fills itself after reset, rejects writes to a protected low region and drives the bus on read hits.
module bus_ram #(
   parameter int BASE_ADDR      = 0,
   parameter int ADDR_WIDTH     = 7,
   parameter int WP_WORDS       = 0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   output logic       READY,
   output logic       WP_ERR
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, RUN} state_t;
   typedef logic [ADDR_WIDTH-1:0] offset_t;

   localparam state_t     RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
   localparam logic [8:0] BASE9       = 9'(BASE_ADDR);
   localparam logic [8:0] DEPTH9      = 9'(DEPTH);

   state_t     state, state_next;
   offset_t    clr_idx, clr_idx_next;
   logic [7:0] mem [DEPTH];
   logic [7:0] rd_data;
   logic       drive_en;

   logic [8:0] rel_addr;
   logic       hit;
   offset_t    offset;
   logic       protected_hit;
   logic       active;

   logic       mem_we;
   offset_t    mem_waddr;
   logic [7:0] mem_wdata;

   // A 9-bit subtraction makes its borrow bit flag addresses below the window.
   assign rel_addr = {1'b0, BUS_ADDR} - BASE9;
   assign hit      = ~rel_addr[8] && (rel_addr < DEPTH9);
   assign offset   = rel_addr[ADDR_WIDTH-1:0];
   assign active   = (state == RUN) && READY;

   if (WP_WORDS > 0) begin : g_wp
      assign protected_hit = (rel_addr < 9'(WP_WORDS));
   end else begin : g_no_wp
      assign protected_hit = 1'b0;
   end

   // NOTE: every signal gets a default first, so no path through the block infers a latch.
   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      mem_we       = 1'b0;
      mem_waddr    = offset;
      mem_wdata    = BUS_DATA;
      case (state)
         CLEAR: begin
            mem_we       = 1'b1;
            mem_waddr    = clr_idx;
            mem_wdata    = 8'h00;
            clr_idx_next = clr_idx + offset_t'(1);
            if (&clr_idx) state_next = RUN;
         end
         RUN: mem_we = active && hit && BUS_WE && !protected_hit;
         default: state_next = RESET_STATE;
      endcase
   end

   // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= RESET_STATE;
         clr_idx  <= '0;
         READY    <= 1'b0;
         WP_ERR   <= 1'b0;
         drive_en <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         state    <= state_next;
         clr_idx  <= clr_idx_next;
         READY    <= (state_next == RUN);
         WP_ERR   <= active && hit && BUS_WE && protected_hit;
         drive_en <= active && hit && !BUS_WE;
         rd_data  <= mem[offset];
      end
   end

   // NOTE: the array has no reset so it maps onto a plain RAM; the clear sequencer initialises it.
   always_ff @(posedge CLK) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign BUS_DATA = drive_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: four bus_ram configurations on private pulled-up buses, checked against an array model.
// A bus reading 8'hFF with nobody driving means the RAM left it high-Z.
module tb_bus_ram;

   localparam int N_DUT = 4;
   localparam int BASE_OF [N_DUT] = '{'h00, 'h80, 'h20, 'hF0};
   localparam int AW_OF   [N_DUT] = '{7, 4, 3, 4};
   localparam int WP_OF   [N_DUT] = '{0, 0, 4, 0};
   localparam bit COR_OF  [N_DUT] = '{1'b1, 1'b1, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic       rst_n [N_DUT];
   logic       we    [N_DUT];
   logic [7:0] addr  [N_DUT];
   logic       drv   [N_DUT];
   logic [7:0] dat   [N_DUT];
   wire        ready [N_DUT];
   wire        wp_err[N_DUT];
   tri1  [7:0] bus0, bus1, bus2, bus3;

   int n_checks;
   int n_errors;

   logic [7:0] model      [N_DUT][256];
   bit         last_drive [N_DUT];
   logic [7:0] last_val   [N_DUT];

   always #5 clk = ~clk;

   assign bus0 = drv[0] ? dat[0] : 8'hzz;
   assign bus1 = drv[1] ? dat[1] : 8'hzz;
   assign bus2 = drv[2] ? dat[2] : 8'hzz;
   assign bus3 = drv[3] ? dat[3] : 8'hzz;

   bus_ram #(.BASE_ADDR(BASE_OF[0]), .ADDR_WIDTH(AW_OF[0]), .WP_WORDS(WP_OF[0]), .CLEAR_ON_RESET(COR_OF[0])) dut0 (
      .CLK(clk), .RESET_N(rst_n[0]), .BUS_DATA(bus0), .BUS_ADDR(addr[0]), .BUS_WE(we[0]),
      .READY(ready[0]), .WP_ERR(wp_err[0]));
   bus_ram #(.BASE_ADDR(BASE_OF[1]), .ADDR_WIDTH(AW_OF[1]), .WP_WORDS(WP_OF[1]), .CLEAR_ON_RESET(COR_OF[1])) dut1 (
      .CLK(clk), .RESET_N(rst_n[1]), .BUS_DATA(bus1), .BUS_ADDR(addr[1]), .BUS_WE(we[1]),
      .READY(ready[1]), .WP_ERR(wp_err[1]));
   bus_ram #(.BASE_ADDR(BASE_OF[2]), .ADDR_WIDTH(AW_OF[2]), .WP_WORDS(WP_OF[2]), .CLEAR_ON_RESET(COR_OF[2])) dut2 (
      .CLK(clk), .RESET_N(rst_n[2]), .BUS_DATA(bus2), .BUS_ADDR(addr[2]), .BUS_WE(we[2]),
      .READY(ready[2]), .WP_ERR(wp_err[2]));
   bus_ram #(.BASE_ADDR(BASE_OF[3]), .ADDR_WIDTH(AW_OF[3]), .WP_WORDS(WP_OF[3]), .CLEAR_ON_RESET(COR_OF[3])) dut3 (
      .CLK(clk), .RESET_N(rst_n[3]), .BUS_DATA(bus3), .BUS_ADDR(addr[3]), .BUS_WE(we[3]),
      .READY(ready[3]), .WP_ERR(wp_err[3]));

   function automatic logic [7:0] bus_of(int d);
      case (d)
         0:       return bus0;
         1:       return bus1;
         2:       return bus2;
         default: return bus3;
      endcase
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear(int d);
      for (int i = 0; i < 256; i++) model[d][i] = 8'h00;
      last_drive[d] = 1'b0;
   endtask

   // One bus cycle: present the access, let one edge sample it, then check bus and WP_ERR.
   task automatic op(int d, bit w, logic [7:0] a, logic [7:0] v, string tag);
      int         off;
      bit         hit;
      bit         exp_wp;
      logic [7:0] exp_bus;
      off = int'(a) - BASE_OF[d];
      hit = (off >= 0) && (off < (1 << AW_OF[d]));
      // While the RAM still drives a previous read, the processor can only write back that same value.
      if (w && last_drive[d]) v = last_val[d];
      exp_bus = (hit && !w) ? model[d][off] : 8'hFF;
      exp_wp  = hit && w && (off < WP_OF[d]);
      we[d]   = w;
      addr[d] = a;
      dat[d]  = v;
      drv[d]  = w;
      @(posedge clk);
      #1;
      drv[d] = 1'b0;
      #1;
      check({tag, " bus"}, bus_of(d), exp_bus);
      check({tag, " wp_err"}, 8'(wp_err[d]), 8'(exp_wp));
      if (hit && w && !exp_wp) model[d][off] = v;
      last_drive[d] = hit && !w;
      last_val[d]   = exp_bus;
   endtask

   task automatic idle(int d);
      op(d, 1'b0, (d == 0) ? 8'hFF : 8'h00, 8'h00, "idle");
   endtask

   // rst_n[d] must have just been released between edges.
   task automatic wait_clear(int d, string tag);
      int n;
      n = 1 << AW_OF[d];
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         check(tag, 8'(ready[d]), 8'(i == n));
      end
   endtask

   task automatic rand_ops(int d, int n);
      int lo, hi;
      lo = BASE_OF[d] - 8;
      hi = BASE_OF[d] + (1 << AW_OF[d]) + 7;
      if (lo < 0) lo = 0;
      if (hi > 255) hi = 255;
      for (int i = 0; i < n; i++) begin
         op(d, bit'($urandom_range(1, 0)), 8'($urandom_range(hi, lo)), 8'($urandom), "rand");
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no completion, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int d = 0; d < N_DUT; d++) begin
         rst_n[d]      = 1'b0;
         we[d]         = 1'b0;
         addr[d]       = (d == 0) ? 8'hFF : 8'h00;
         drv[d]        = 1'b0;
         dat[d]        = 8'h00;
         last_drive[d] = 1'b0;
         last_val[d]   = 8'hFF;
      end

      // Reset values, before and after edges in reset.
      #2;
      for (int d = 0; d < N_DUT; d++) begin
         check("reset ready", 8'(ready[d]), 8'h00);
         check("reset wp_err", 8'(wp_err[d]), 8'h00);
         check("reset bus", bus_of(d), 8'hFF);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset hold ready", 8'(ready[0]), 8'h00);

      // Default clear: a write to 0x05 held throughout the clear must be ignored.
      we[0]   = 1'b1;
      addr[0] = 8'h05;
      dat[0]  = 8'hAA;
      drv[0]  = 1'b1;
      rst_n[0] = 1'b1;
      wait_clear(0, "clear0 ready");
      drv[0] = 1'b0;
      model_clear(0);
      op(0, 1'b0, 8'h05, 8'h00, "clear0 r05");

      // Reset in the middle of a driven read.
      op(0, 1'b1, 8'h05, 8'h5A, "d0 w05");
      op(0, 1'b0, 8'h05, 8'h00, "d0 r05");
      rst_n[0] = 1'b0;
      #1;
      check("async rst ready", 8'(ready[0]), 8'h00);
      check("async rst bus", bus0, 8'hFF);
      check("async rst wp_err", 8'(wp_err[0]), 8'h00);
      we[0]   = 1'b0;
      addr[0] = 8'hFF;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;

      // Reset again at clear cycle 50; sequencer must restart from offset 0.
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
      end
      check("clear50 ready", 8'(ready[0]), 8'h00);
      rst_n[0] = 1'b0;
      #1;
      check("midclear ready", 8'(ready[0]), 8'h00);
      check("midclear bus", bus0, 8'hFF);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      wait_clear(0, "reclear ready");
      model_clear(0);
      op(0, 1'b0, 8'h05, 8'h00, "reclear r05");
      op(0, 1'b0, 8'h7F, 8'h00, "d0 r7F");
      op(0, 1'b0, 8'h80, 8'h00, "d0 miss80");

      // Release the other three together; dut3 skips the clear.
      rst_n[1] = 1'b1;
      rst_n[2] = 1'b1;
      rst_n[3] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         check("d1 ready", 8'(ready[1]), 8'(i >= 16));
         check("d2 ready", 8'(ready[2]), 8'(i >= 8));
         check("d3 ready", 8'(ready[3]), 8'h01);
      end
      model_clear(1);
      model_clear(2);

      // Window at 0x80..0x8F: read-after-write, edges of the window, misses on both sides.
      op(1, 1'b1, 8'h83, 8'h3C, "d1 w83");
      op(1, 1'b0, 8'h83, 8'h00, "d1 r83");
      op(1, 1'b0, 8'h8F, 8'h00, "d1 r8F");
      op(1, 1'b0, 8'h90, 8'h00, "d1 miss90");
      op(1, 1'b0, 8'h7F, 8'h00, "d1 miss7F");
      for (int i = 0; i < 4; i++) op(1, 1'b1, 8'(8'h80 + i), 8'(8'h10 + i), "d1 wseq");
      for (int i = 0; i < 4; i++) op(1, 1'b0, 8'(8'h80 + i), 8'h00, "d1 b2b");
      idle(1);
      op(1, 1'b1, 8'h85, 8'h66, "d1 w85");
      for (int i = 0; i < 6; i++) begin
         op(1, 1'b0, 8'h85, 8'h00, "contend rd");
         op(1, 1'b1, 8'h85, 8'(8'h40 + i), "contend wr");
      end
      rand_ops(1, 150);

      // Protected region: offsets 0..3 of the window at 0x20..0x27.
      idle(2);
      op(2, 1'b1, 8'h22, 8'hFF, "wp w22");
      op(2, 1'b0, 8'h22, 8'h00, "wp r22");
      idle(2);
      op(2, 1'b1, 8'h24, 8'hFF, "wp w24");
      op(2, 1'b0, 8'h24, 8'h00, "wp r24");
      idle(2);
      op(2, 1'b1, 8'h25, 8'h5A, "wp w25");
      op(2, 1'b0, 8'h25, 8'h00, "wp r25");
      idle(2);
      op(2, 1'b1, 8'h20, 8'h77, "wp w20");
      op(2, 1'b1, 8'h23, 8'h77, "wp w23");
      op(2, 1'b0, 8'h20, 8'h00, "wp r20");
      op(2, 1'b0, 8'h28, 8'h00, "wp miss28");
      op(2, 1'b0, 8'h1F, 8'h00, "wp miss1F");
      rand_ops(2, 150);

      // Window ending at the top of the address space, no clear sequencer.
      idle(3);
      op(3, 1'b1, 8'hFF, 8'h77, "d3 wFF");
      op(3, 1'b0, 8'hFF, 8'h00, "d3 rFF");
      op(3, 1'b0, 8'hEF, 8'h00, "d3 missEF");
      op(3, 1'b1, 8'hF0, 8'h21, "d3 wF0");
      op(3, 1'b0, 8'hF0, 8'h00, "d3 rF0");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised single-port data RAM for the shared 8-bit processor bus. It generalises the fixed 128x8 bus RAM in four ways: a configurable base address and depth, a power-up clear sequencer, a write-protected low region, and status outputs. It sits on BUS_DATA/BUS_ADDR/BUS_WE beside the ROM and peripherals. When the processor reads an address in its window, it drives the tristate data bus.

## Interface
- BASE_ADDR, 0: first bus address decoded by this RAM.
- ADDR_WIDTH, 7: depth is 2**ADDR_WIDTH words. Legal only if BASE_ADDR + 2**ADDR_WIDTH <= 256.
- WP_WORDS, 0: words at offsets 0..WP_WORDS-1 are write-protected. 0 disables protection.
- CLEAR_ON_RESET, 1: 1 runs the zero-fill sequencer after reset; 0 skips it.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus. Driven only during a read-hit cycle, otherwise high-Z.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  1 = processor write, 0 = read.
- READY  output  1  1 when the RAM accepts bus accesses. 0 during clear and reset.
- WP_ERR  output  1  one-cycle pulse on a rejected write to the protected region.

## Operation
- Decode: hit = (BUS_ADDR >= BASE_ADDR) and (BUS_ADDR < BASE_ADDR + 2**ADDR_WIDTH). The offset is BUS_ADDR - BASE_ADDR, truncated to ADDR_WIDTH bits.
- FSM has two states, CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR writes 8'h00 to offset clr_idx and increments clr_idx once per cycle from 0.
  - At clr_idx = 2**ADDR_WIDTH-1, that word is written and the FSM moves to RUN.
  - RUN is terminal until the next reset.
- In CLEAR, bus accesses are ignored: no write, no drive, no WP_ERR. The processor must poll or wait on READY.
- RUN, write: a hit with BUS_WE=1 and offset >= WP_WORDS writes BUS_DATA to Mem[offset].
- RUN, protected write: a hit with BUS_WE=1 and offset < WP_WORDS leaves memory unchanged and pulses WP_ERR on the next cycle.
- RUN, read: a hit with BUS_WE=0 sets the registered drive enable. The output register loads Mem[offset] on every edge regardless of hit.
- The drive enable clears on any edge with no hit, BUS_WE=1, or state not RUN.
- Misses never touch memory or the bus.
- Protected words are initialised only by the clear sequencer. Preloaded contents are not guaranteed when CLEAR_ON_RESET=1.

## Timing
- Reset values:
  - drive enable 0, so BUS_DATA is high-Z.
  - output register 8'h00.
  - READY 0, WP_ERR 0, clr_idx 0.
  - Memory contents are not reset by RESET_N itself.
- READY rises on the edge where the FSM enters RUN:
  - CLEAR_ON_RESET=1: 2**ADDR_WIDTH edges after RESET_N deasserts (128 for defaults).
  - CLEAR_ON_RESET=0: the first edge after RESET_N deasserts.
- Read latency is 1 cycle. The address sampled at edge k is driven on BUS_DATA from edge k until edge k+1, and is valid for sampling at edge k+1.
- Back-to-back reads are supported, one per cycle. The data follows the address with a 1-cycle lag.
- Read-after-write: a write at edge k followed by a read of the same offset sampled at edge k+1 returns the new data at edge k+2. There is no forwarding path.
- Write to a read: the drive enable drops on the edge that samples BUS_WE=1. The bus is therefore high-Z while the processor drives write data.
- RESET_N asserted mid-clear or mid-access forces all reset values immediately and asynchronously. The sequencer restarts from offset 0 after deassertion.
- WP_ERR is registered: high for exactly one cycle after each offending edge. It stays high on consecutive cycles for consecutive protected writes.
- Addresses at BASE_ADDR + 2**ADDR_WIDTH and above, or below BASE_ADDR, are misses. No aliasing from offset wrap-around.

## Test plan
- Clear sequence, defaults: release RESET_N, then hold BUS_WE=1 to address 8'h05 with data 8'hAA throughout clear. Required:
  - READY=0 for 128 cycles, then 1.
  - A read of 8'h05 returns 8'h00.
  - The write was ignored.
- Read/write, BASE_ADDR=8'h80, ADDR_WIDTH=4:
  - write 8'h3C to 8'h83 -> reading 8'h83 returns 8'h3C one cycle after the address.
  - reading 8'h90 or 8'h7F -> BUS_DATA stays high-Z.
- Write protect, WP_WORDS=4:
  - write 8'hFF to offset 2 -> WP_ERR high for 1 cycle; offset 2 still reads 8'h00.
  - write 8'hFF to offset 4 -> no WP_ERR; offset 4 reads 8'hFF.
- Back-to-back reads: after writing offsets 0..3 with 8'h10..8'h13, read 0,1,2,3 on consecutive cycles -> BUS_DATA shows 8'h10..8'h13 on consecutive cycles, each lagging its address by one cycle.
- Reset mid-clear: assert RESET_N low at clear cycle 50 for 2 cycles -> outputs return to reset values at once, and READY rises 128 cycles after the second release.
- Bus contention: alternate read and write every cycle to the same hit address -> BUS_DATA is never driven by the RAM in a cycle where BUS_WE=1 was sampled.
